mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and mem_responder.
// The master modport is the initiator side. The slave modport is the responder side.
interface mem_responder_if #(
    parameter int BUS_WIDTH = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 WE;
    logic [BUS_WIDTH-1:0] A;
    logic [BUS_WIDTH-1:0] WD;
    logic                 resp_valid;
    logic [BUS_WIDTH-1:0] RD;
    logic                 err;

    modport master (
        output req_valid, WE, A, WD,
        input  req_ready, resp_valid, RD, err
    );

    modport slave (
        input  req_valid, WE, A, WD,
        output req_ready, resp_valid, RD, err
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: a byte-wide storage of 2^ADDR_BITS locations behind a word-wide request bus.
// An accepted request moves one byte per cycle through the storage in XFER.
// Byte order is little-endian, and the address wraps at the top of storage.
// The responder then reports completion with a one-cycle resp_valid pulse in RESP.
// Optional feature macro: MEM_MISALIGN_CHECK_EN. When it is defined, requests with A[1:0] != 0
// are rejected with err=1 and make no storage access. When it is undefined, err is tied to 0.
module mem_responder #(
    parameter int BUS_WIDTH  = 32,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 10
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  mem_if
);
    localparam int NBYTES = BUS_WIDTH / DATA_WIDTH;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 we_q;
    logic [ADDR_BITS-1:0] base_q;
    logic [BUS_WIDTH-1:0] wd_q;
    logic [BUS_WIDTH-1:0] rd_buf_q;
    logic [BUS_WIDTH-1:0] rd_q;
    logic                 req_ready_q;
    logic                 resp_valid_q;
    logic [DATA_WIDTH-1:0] mem_q [0:(1 << ADDR_BITS) - 1];

    logic [ADDR_BITS-1:0]  byte_addr_s;
    logic [DATA_WIDTH-1:0] wr_byte_s;
    logic [DATA_WIDTH-1:0] rd_byte_s;
    logic [BUS_WIDTH-1:0]  rd_word_s;
    logic                  accept_s;

    // The address bits above the storage size are intentionally ignored.
    logic unused_addr_s;
    assign unused_addr_s = ^mem_if.A[BUS_WIDTH-1:ADDR_BITS];

`ifdef MEM_MISALIGN_CHECK_EN
    logic err_q;
    logic mis_s;
    assign mis_s = (mem_if.A[1:0] != 2'b00);
`endif

    // Compute the current byte lane, its wrapped storage address, and the partially assembled read word.
    always_comb begin
        byte_addr_s = base_q + ADDR_BITS'(cnt_q);
        wr_byte_s   = wd_q[32'(cnt_q) * DATA_WIDTH +: DATA_WIDTH];
        rd_byte_s   = mem_q[byte_addr_s];
        rd_word_s   = rd_buf_q;
        rd_word_s[32'(cnt_q) * DATA_WIDTH +: DATA_WIDTH] = rd_byte_s;
        accept_s    = mem_if.req_valid && req_ready_q;
    end

    // Control FSM: IDLE accepts a request, XFER walks the bytes, and RESP strobes completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            base_q       <= '0;
            wd_q         <= '0;
            rd_buf_q     <= '0;
            rd_q         <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    resp_valid_q <= 1'b0;
                    if (accept_s) begin
                        we_q        <= mem_if.WE;
                        base_q      <= mem_if.A[ADDR_BITS-1:0];
                        wd_q        <= mem_if.WD;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
                        if (mis_s) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            err_q        <= 1'b1;
                            rd_q         <= '0;
                        end else begin
                            state_q      <= XFER;
                            err_q        <= 1'b0;
                        end
`else
                        state_q     <= XFER;
`endif
                    end
                end
                XFER: begin
                    if (!we_q) begin
                        rd_buf_q <= rd_word_s;
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        rd_q         <= we_q ? wd_q : rd_word_s;
                    end else begin
                        cnt_q        <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    cnt_q        <= '0;
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    cnt_q        <= '0;
                end
            endcase
        end
    end

    // Storage write port. Reset is not applied to the contents.
    // A reset edge suppresses the byte that would otherwise have been written on that edge.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == XFER) && we_q) begin
            mem_q[byte_addr_s] <= wr_byte_s;
        end
    end

    assign mem_if.req_ready  = req_ready_q;
    assign mem_if.resp_valid = resp_valid_q;
    assign mem_if.RD         = rd_q;
`ifdef MEM_MISALIGN_CHECK_EN
    assign mem_if.err        = err_q;
`else
    assign mem_if.err        = 1'b0;
`endif
endmodule
